// File: rtl/nn_loader_pkg.sv
// Shared definitions for the ROM loader / unit receiver / network controller path.
package nn_loader_pkg;

  // Default bus geometry, shared by the loader and the network controller.
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_UNITS = 4;
  localparam int DEF_ADDR_W    = 2;

  // Receiver sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rx_state_t;

endpackage

// File: rtl/unit_data_receiver_reg_file.sv
// Unit word storage with a written-slot mask. all_written folds in the
// write happening this cycle so a write coinciding with start still counts.
module unit_reg_file
  import nn_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_clear_mask,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_all_written
);

  logic [DATA_W-1:0]    r_mem [NUM_UNITS];
  logic [NUM_UNITS-1:0] r_written;
  logic [NUM_UNITS-1:0] w_wr_onehot;

  // Decode the write address into a per-slot strobe (caller guarantees range).
  always_comb begin
    w_wr_onehot = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      w_wr_onehot[i] = i_wr_en && (i_wr_addr == ADDR_W'(i));
  end

  // Word storage; survives the mask clear so the last stream stays readable.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_UNITS; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++)
        if (w_wr_onehot[i]) r_mem[i] <= i_wr_data;
    end
  end

  // Written mask, cleared once a stream has completed.
  always_ff @(posedge clk) begin
    if (reset || i_clear_mask) r_written <= '0;
    else                       r_written <= r_written | w_wr_onehot;
  end

  // Completeness including the same-cycle write.
  assign o_all_written = &(r_written | w_wr_onehot);

  // Combinational read mux.
  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (i_rd_addr == ADDR_W'(i)) o_rd_data = r_mem[i];
  end

endmodule

// File: rtl/unit_data_receiver.sv
// Receives unit words from the ROM loader and, on start, streams them in
// index order to the network controller over valid/ready, then pulses done.
module unit_data_receiver
  import nn_loader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_start_in,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_index,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_incomplete,
  output logic              o_err_overrun
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_UNITS - 1);

  rx_state_t         r_state, w_next;
  logic [ADDR_W-1:0] r_index;
  logic              r_err_inc, r_err_ovr;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_all_written, w_idle, w_addr_ok, w_wr_accept;
  logic              w_hs, w_start_ok, w_start_bad;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_addr_ok   = ({1'b0, i_wr_addr} < (ADDR_W + 1)'(NUM_UNITS));
  assign w_wr_accept = i_wr_en && w_idle && w_addr_ok;
  assign w_hs        = (r_state == ST_STREAM) && i_out_ready;
  assign w_start_ok  = w_idle && i_start_in && w_all_written;
  assign w_start_bad = w_idle && i_start_in && !w_all_written;

  unit_reg_file #(
    .DATA_W   (DATA_W),
    .NUM_UNITS(NUM_UNITS),
    .ADDR_W   (ADDR_W)
  ) u_regs (
    .clk          (clk),
    .reset        (reset),
    .i_wr_en      (w_wr_accept),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_clear_mask (r_state == ST_DONE),
    .i_rd_addr    (r_index),
    .o_rd_data    (w_rd_data),
    .o_all_written(w_all_written)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state: start only on a complete mask, DONE after the last handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start_ok) w_next = ST_STREAM;
      ST_STREAM: if (w_hs && r_index == LAST_IDX) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs; data and index read straight from registers so they hold under stall.
  always_comb begin
    o_out_valid = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_out_last  = 1'b0;
    o_out_data  = '0;
    o_out_index = '0;
    case (r_state)
      ST_STREAM: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
        o_out_data  = w_rd_data;
        o_out_index = r_index;
        o_out_last  = (r_index == LAST_IDX);
      end
      ST_DONE: begin
        o_busy = 1'b1;
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Stream index: reset on start and after completion, advance per handshake.
  always_ff @(posedge clk) begin
    if (reset || r_state == ST_DONE || w_start_ok) r_index <= '0;
    else if (w_hs && r_index != LAST_IDX)          r_index <= r_index + 1'b1;
  end

  // Sticky error flags; they only report, never stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err_inc <= 1'b0;
      r_err_ovr <= 1'b0;
    end else begin
      if (w_start_bad)                           r_err_inc <= 1'b1;
      if (i_wr_en && (!w_idle || !w_addr_ok))    r_err_ovr <= 1'b1;
    end
  end

  assign o_err_incomplete = r_err_inc;
  assign o_err_overrun    = r_err_ovr;

endmodule

// File: doc/unit_data_receiver.md
Name: unit_data_receiver

Overview:
- Receiving end of the ROM-loader write interface. Captures per-unit 32-bit words from the loader's address/write-strobe/data bus into a small register bank.
- On the loader's start pulse, checks that every unit slot was written. It then streams the words in index order to the network controller over a valid/ready handshake, and pulses done when finished.
- Sits between the ROM loader and the neural-network controller.

Parameters:
- DATA_W, 32, width of one unit word.
- NUM_UNITS, 4, number of unit slots (1..2**ADDR_W).
- ADDR_W, 2, width of write address and out_index.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe from loader; one word per cycle it is high.
- wr_addr  in  ADDR_W  slot index for the write.
- wr_data  in  DATA_W  word to store.
- start_in  in  1  loader's "all units sent" pulse; level sampled each cycle.
- out_data  out  DATA_W  word being offered to the network controller.
- out_index  out  ADDR_W  slot index of out_data.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  network controller accepts the word when high together with out_valid.
- out_last  out  1  high with out_valid when out_index == NUM_UNITS-1.
- busy  out  1  high in STREAM and DONE.
- done  out  1  one-cycle pulse after the last word is accepted.
- err_incomplete  out  1  sticky; start_in arrived with unwritten slots.
- err_overrun  out  1  sticky; write while busy, or wr_addr >= NUM_UNITS.

Behaviour:
- Reset values: all outputs 0. Storage cleared to 0, written mask 0, index 0, state IDLE. Reset mid-stream aborts immediately; no done pulse.
- States:
  - IDLE: busy=0, out_valid=0.
  - STREAM: out_valid=1, busy=1.
  - DONE: done=1, busy=1, out_valid=0; lasts exactly 1 cycle, then IDLE.
- Writes in IDLE:
  - wr_en with wr_addr < NUM_UNITS stores wr_data and sets written[wr_addr].
  - Rewriting a slot overwrites it; this is not an error.
  - wr_addr >= NUM_UNITS: word dropped, err_overrun set.
- start_in in IDLE:
  - Completeness is evaluated on the written mask including a same-cycle write. Simultaneous write+start therefore counts that write, and the new data is what gets streamed.
  - Complete: go to STREAM next cycle with index=0. Latency is start_in at cycle N -> out_valid=1 at N+1.
  - Incomplete: stay IDLE and set err_incomplete; the mask is retained.
- STREAM:
  - out_data = stored[index], driven from registers.
  - out_data and out_index are held stable while out_valid && !out_ready.
  - On handshake: if index == NUM_UNITS-1, go to DONE; else index+1.
  - Back-to-back handshakes give one word per cycle.
- DONE: clear the written mask and index; stored data is kept.
- While busy: wr_en is ignored (storage unchanged) and sets err_overrun; start_in is ignored with no error.
- Error flags are cleared only by reset. Errors never block operation.
- Index arithmetic is ADDR_W bits and never exceeds NUM_UNITS-1.
- NUM_UNITS=1: out_last is high on the single word.

Decomposition:
- Shared package nn_loader_pkg holds:
  - state encoding (IDLE, STREAM, DONE);
  - default DATA_W, NUM_UNITS, ADDR_W constants, shared with the ROM loader and network controller.
- One sub-module, unit_reg_file: NUM_UNITS x DATA_W storage, written mask, all_written flag (including same-cycle write), clear_mask input, combinational read port.
- The FSM, index counter, handshake and error logic live in unit_data_receiver.

Test Plan:
- Write 0x11111111, 0x22222222, 0x33333333, 0x44444444 to addr 0..3, pulse start_in, out_ready tied 1 -> out_valid for 4 consecutive cycles starting the cycle after start. Words in order, out_index 0..3, out_last only on index 3, done pulse the cycle after, busy low after done.
- Same loads, out_ready toggled 1,0,0,1,1,0,1 -> each word held stable while stalled; exactly 4 handshakes in order; done one cycle after the 4th.
- Write only addr 0..2, pulse start_in -> stays IDLE, out_valid never asserts, err_incomplete=1. Then write addr 3 and pulse start -> normal stream, err_incomplete stays 1.
- Write addr 0..2 earlier, then write addr 3 = 0xDEADBEEF in the same cycle as start_in -> stream starts; word 3 = 0xDEADBEEF.
- During STREAM, wr_en to addr 1 = 0xFFFFFFFF -> err_overrun=1, word 1 still the old value. Assert reset after the 2nd handshake -> all outputs 0 next cycle, no done; a subsequent start_in without rewrites sets err_incomplete.
- Write addr 2 twice (0xAAAA0000 then 0x0000BBBB) -> streamed word 2 = 0x0000BBBB, no error flags.
